sd_sector_streamer: RTL and testbench
=====================================

SD_SECTOR_STREAMER -- requirements
Module: sd_sector_streamer

Interface
REQ-001 Parameter SECTOR_BITS, default 4096, bits per SD sector buffer.
REQ-002 Parameter WORD_W, default 16, width of each streamed word; WORDS = SECTOR_BITS/WORD_W = 256.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to stream a sector; honoured only in IDLE.
REQ-006 first_word  input  8  word index of first word; sampled with start.
REQ-007 word_cnt_m1  input  8  number of words minus one (0 = 1 word, 255 = 256 words); sampled with start.
REQ-008 sec_valid  input  1  SD core holds a complete sector on sec_data.
REQ-009 sec_data  input  4096  sector image from SD core.
REQ-010 sec_ack  output  1  one-cycle pulse releasing the sector to the SD core.
REQ-011 out_data  output  16  streamed word.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-014 out_last  output  1  high with the final word of the transfer.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when the transfer completes.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_SEC, LOAD, STREAM, ACK.
REQ-018 IDLE->WAIT_SEC on start; first_word into ptr, word_cnt_m1 into remaining counter.
REQ-019 WAIT_SEC->LOAD on sec_valid; sec_data is copied into an internal 4096-bit buffer in that cycle.
REQ-020 LOAD->STREAM unconditionally; out_valid rises first cycle of STREAM (2 cycles after sec_valid sampled).
REQ-021 Word k SHALL be buffer bits k*16 .. k*16+15 with bit k*16 mapped to out_data[15] and bit k*16+15 to out_data[0].
REQ-022 out_data/out_valid/out_last SHALL remain stable while out_valid && !out_ready.
REQ-023 On each handshake ptr increments modulo 256 (255 wraps to 0) and remaining decrements.
REQ-024 out_last SHALL be high iff out_valid and remaining == 0.
REQ-025 Handshake with out_last -> ACK; ACK asserts sec_ack and done for exactly one cycle, then IDLE.
REQ-026 start outside IDLE SHALL be ignored, with no effect on ptr, counters or outputs.
REQ-027 sec_valid outside WAIT_SEC SHALL be ignored; sec_data changes after LOAD do not affect output words.
REQ-028 out_valid SHALL be low in all states other than STREAM.

Reset
REQ-029 rst_n low at a clock edge SHALL force IDLE, ptr=0, remaining=0, buffer contents don't-care.
REQ-030 During reset and the cycle after: out_valid=0, out_last=0, sec_ack=0, done=0, busy=0, out_data=0.
REQ-031 Reset mid-transfer SHALL abandon it without emitting sec_ack or done.

Configuration
REQ-032 Macro SD_BYTE_SWAP_EN defined: out_data SHALL be the REQ-021 word with bytes exchanged ([15:8]<->[7:0]).
REQ-033 Macro undefined: out_data SHALL be exactly the REQ-021 word; timing identical in both builds.

Structure
REQ-034 Shared package sd_pkg SHALL hold SECTOR_BITS, WORD_W, WORDS, pointer width (8) and the FSM state encoding.
REQ-035 Word extraction SHALL be a combinational sub-module sd_word_sel (buffer + 8-bit index -> 16-bit word); FSM, counters, buffer and handshake stay in the top.

Verification
REQ-036 Sector bit i = (i%16==0) only (each word 0x8000); start, first_word=0, cnt_m1=255, out_ready=1 -> 256 words of 0x8000, out_last on 256th, then sec_ack+done same cycle.
REQ-037 Sector word k = k; first_word=0xFE, cnt_m1=3 -> words 0x00FE,0x00FF,0x0000,0x0001 (wrap), out_last on 4th.
REQ-038 out_ready toggled 1/0 every cycle -> each word held stable while stalled, no word skipped or duplicated.
REQ-039 start pulsed during STREAM and sec_data changed after LOAD -> stream unchanged, single done.
REQ-040 rst_n low during STREAM word 10 -> outputs zero next cycle, no sec_ack; new start then streams correctly.
REQ-041 Build with SD_BYTE_SWAP_EN, word k = 0x1234 -> out_data 0x3412; without macro -> 0x1234.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants and FSM state encoding for the SD sector streamer.
package sd_pkg;

    localparam int SECTOR_BITS = 4096;
    localparam int WORD_W      = 16;
    localparam int WORDS       = SECTOR_BITS / WORD_W;
    localparam int PTR_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SEC = 3'd1,
        ST_LOAD     = 3'd2,
        ST_STREAM   = 3'd3,
        ST_ACK      = 3'd4
    } state_e;

endpackage

// File: rtl/sd_word_sel.sv
// Combinational word picker: returns word idx_i of the sector buffer with the
// lowest buffer bit of the word placed on the MSB of the output.
module sd_word_sel #(
    parameter int SECTOR_BITS = sd_pkg::SECTOR_BITS,
    parameter int WORD_W      = sd_pkg::WORD_W
) (
    input  logic [SECTOR_BITS-1:0]   buf_i,
    input  logic [sd_pkg::PTR_W-1:0] idx_i,
    output logic [WORD_W-1:0]        word_o
);

    logic [WORD_W-1:0] seg;

    // Slice out the word, then reverse its bit order.
    always_comb begin
        seg    = buf_i[int'(idx_i) * WORD_W +: WORD_W];
        word_o = '0;
        for (int j = 0; j < WORD_W; j++) begin
            word_o[WORD_W-1-j] = seg[j];
        end
    end

endmodule

// File: rtl/sd_sector_streamer.sv
// SD sector streamer: captures a full sector from the SD core and streams a
// window of words (with pointer wrap-around) over a valid/ready interface.
// Optional build macro SD_BYTE_SWAP_EN exchanges the bytes of each output word.
//
// state       | meaning
// ST_IDLE     | waiting for start
// ST_WAIT_SEC | request accepted, waiting for the SD core's sector
// ST_LOAD     | sector captured, presenting first word next cycle
// ST_STREAM   | words offered to the consumer
// ST_ACK      | one-cycle sec_ack/done, then back to idle
module sd_sector_streamer #(
    parameter int SECTOR_BITS = sd_pkg::SECTOR_BITS,
    parameter int WORD_W      = sd_pkg::WORD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             first_word,
    input  logic [7:0]             word_cnt_m1,
    input  logic                   sec_valid,
    input  logic [SECTOR_BITS-1:0] sec_data,
    output logic                   sec_ack,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    import sd_pkg::*;

    state_e                   state_q;
    logic [PTR_W-1:0]         ptr_q;
    logic [PTR_W-1:0]         rem_q;
    logic [SECTOR_BITS-1:0]   buf_q;
    logic                     out_valid_q;
    logic                     out_last_q;
    logic                     sec_ack_q;
    logic                     done_q;
    logic                     busy_q;
    logic [WORD_W-1:0]        word_raw;
    logic [WORD_W-1:0]        word_fmt;

    sd_word_sel #(
        .SECTOR_BITS (SECTOR_BITS),
        .WORD_W      (WORD_W)
    ) u_word_sel (
        .buf_i  (buf_q),
        .idx_i  (ptr_q),
        .word_o (word_raw)
    );

    // Sequencer, counters, sector buffer and registered handshake outputs.
    // The buffer is deliberately left out of reset; its contents are only
    // observed after a fresh capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sec_ack_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sec_ack_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ptr_q   <= first_word;
                        rem_q   <= word_cnt_m1;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT_SEC;
                    end
                end
                ST_WAIT_SEC: begin
                    if (sec_valid) begin
                        buf_q   <= sec_data;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    out_valid_q <= 1'b1;
                    out_last_q  <= (rem_q == '0);
                    state_q     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        ptr_q <= ptr_q + 8'd1;
                        if (rem_q == '0) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            sec_ack_q   <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= ST_ACK;
                        end else begin
                            rem_q      <= rem_q - 8'd1;
                            out_last_q <= (rem_q == 8'd1);
                        end
                    end
                end
                ST_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Optional byte exchange; same path depth in both builds.
    always_comb begin
`ifdef SD_BYTE_SWAP_EN
        word_fmt = {word_raw[7:0], word_raw[15:8]};
`else
        word_fmt = word_raw;
`endif
    end

    // Data is forced to zero whenever no word is offered.
    assign out_data  = out_valid_q ? word_fmt : '0;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign sec_ack   = sec_ack_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Randomized self-checking bench for sd_sector_streamer with a word-queue
// reference model derived from the sector layout rules.
module tb_sd_sector_streamer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    first_word;
    logic [7:0]    word_cnt_m1;
    logic          sec_valid;
    logic [4095:0] sec_data;
    logic          sec_ack;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [4095:0] sec_img;
    int            n_err = 0;
    int            n_chk = 0;

    always #5 clk = ~clk;

    sd_sector_streamer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .first_word  (first_word),
        .word_cnt_m1 (word_cnt_m1),
        .sec_valid   (sec_valid),
        .sec_data    (sec_data),
        .sec_ack     (sec_ack),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input int k, input logic [15:0] v);
        for (int j = 0; j < 16; j++) sec_img[k*16 + j] = v[15-j];
    endtask

    function automatic logic [15:0] exp_word(input int k);
        logic [15:0] w;
        for (int j = 0; j < 16; j++) w[15-j] = sec_img[k*16 + j];
`ifdef SD_BYTE_SWAP_EN
        w = {w[7:0], w[15:8]};
`endif
        return w;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"},  out_last,  0);
        check({tag, "_ack"},   sec_ack,   0);
        check({tag, "_done"},  done,      0);
        check({tag, "_busy"},  busy,      0);
        check({tag, "_data"},  out_data,  0);
    endtask

    // ready_mode: 0 always ready, 1 toggle, 2 random.
    // abort_at >= 0 applies reset while that word (0-based) is offered.
    task automatic run_xfer(input logic [7:0] fw, input logic [7:0] cm1,
                            input int ready_mode, input bit disturb, input int abort_at);
        logic [15:0] q[$];
        int hs;
        int cyc;
        bit tog;
        hs  = 0;
        cyc = 0;
        tog = 1'b1;
        for (int i = 0; i <= int'(cm1); i++) q.push_back(exp_word((int'(fw) + i) % 256));

        out_ready   = 1'b0;
        start       = 1'b1;
        first_word  = fw;
        word_cnt_m1 = cm1;
        step();
        start       = 1'b0;
        first_word  = 8'($urandom);
        word_cnt_m1 = 8'($urandom);
        check("busy_wait", busy, 1);
        check("valid_wait", out_valid, 0);
        repeat ($urandom_range(0, 3)) begin
            sec_data = {128{$urandom}};
            step();
            check("valid_wait2", out_valid, 0);
        end
        sec_valid = 1'b1;
        sec_data  = sec_img;
        step();
        sec_valid = 1'b0;
        check("valid_load", out_valid, 0);
        if (disturb) sec_data = ~sec_img;
        step();
        check("valid_first", out_valid, 1);

        while (q.size() > 0 && cyc < 4000) begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = tog; tog = !tog; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (disturb && cyc == 5) begin
                start       = 1'b1;
                first_word  = 8'h00;
                word_cnt_m1 = 8'h00;
                sec_valid   = 1'b1;
            end else begin
                start     = 1'b0;
                sec_valid = 1'b0;
            end
            check("valid", out_valid, 1);
            check("data", out_data, q[0]);
            check("last", out_last, (q.size() == 1) ? 1 : 0);
            check("ack_early", sec_ack | done, 0);
            if (abort_at >= 0 && hs == abort_at) begin
                rst_n     = 1'b0;
                out_ready = 1'b0;
                start     = 1'b0;
                sec_valid = 1'b0;
                step();
                check_quiet("rst_in");
                rst_n = 1'b1;
                step();
                check_quiet("rst_after");
                repeat (3) begin
                    step();
                    check_quiet("rst_idle");
                end
                return;
            end
            if (out_ready) begin
                void'(q.pop_front());
                hs++;
            end
            step();
            cyc++;
        end
        start     = 1'b0;
        sec_valid = 1'b0;
        out_ready = 1'b0;
        check("words_left", q.size(), 0);
        check("ack", sec_ack, 1);
        check("done", done, 1);
        check("valid_ack", out_valid, 0);
        check("busy_ack", busy, 1);
        step();
        check("ack_pulse", sec_ack, 0);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        step();
        check("done_single", done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        first_word  = 8'h00;
        word_cnt_m1 = 8'h00;
        sec_valid   = 1'b0;
        sec_data    = '0;
        out_ready   = 1'b0;
        sec_img     = '0;

        step();
        step();
        check_quiet("reset");
        rst_n = 1'b1;
        step();
        check_quiet("reset_after");

        // one set bit per word at the word's lowest buffer bit
        sec_img = '0;
        for (int i = 0; i < 4096; i += 16) sec_img[i] = 1'b1;
        run_xfer(8'h00, 8'hFF, 0, 1'b0, -1);

        // word k holds k, window wraps past 255
        for (int k = 0; k < 256; k++) put_word(k, 16'(k));
        run_xfer(8'hFE, 8'h03, 0, 1'b0, -1);
        run_xfer(8'h10, 8'h00, 0, 1'b0, -1);

        // alternating ready
        run_xfer(8'h40, 8'h1F, 1, 1'b0, -1);

        // ignored start/sec_valid and sector change after capture
        run_xfer(8'h80, 8'h14, 2, 1'b1, -1);

        // reset during word 10, then a clean transfer
        for (int k = 0; k < 256; k++) put_word(k, 16'($urandom));
        run_xfer(8'h20, 8'h1F, 0, 1'b0, 10);
        run_xfer(8'h20, 8'h1F, 0, 1'b0, -1);

        // constant pattern for the byte-order check
        for (int k = 0; k < 256; k++) put_word(k, 16'h1234);
        run_xfer(8'h05, 8'h02, 0, 1'b0, -1);
`ifdef SD_BYTE_SWAP_EN
        check("swap_model", exp_word(5), 16'h3412);
`else
        check("swap_model", exp_word(5), 16'h1234);
`endif

        // random sectors, windows and back-pressure
        for (int t = 0; t < 8; t++) begin
            for (int w = 0; w < 128; w++) sec_img[w*32 +: 32] = $urandom;
            run_xfer(8'($urandom), (t == 7) ? 8'hFF : 8'($urandom_range(0, 40)),
                     2, 1'(t % 2), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
